// File: rtl/fanout_fork_buffered.sv
// rtl/fanout_fork_buffered.sv - buffered broadcast fork with eager/lazy delivery
//
// Purpose: accepts one valid/ready stream, buffers tokens in a small FIFO and
// broadcasts each token to the consumers selected when it was pushed.
//
// Ports:
//   CLK, ASYNCRESET      clock, asynchronous active-high reset
//   flush                synchronous clear of all buffered tokens
//   cfg_en, cfg_sel      route mask = cfg_en & cfg_sel, sampled at push
//   cfg_eager            1 = consumers take the head independently, 0 = all together
//   in_data/valid/ready  upstream stream
//   out_data             head token, shared by all consumers
//   out_valid/ready      per-consumer handshake
//   busy                 FIFO non-empty
//   xfer_count           fully delivered tokens, saturating
module fanout_fork_buffered #(
   parameter int NUM_OUT = 7,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 2,
   parameter int CNT_W   = 16
) (
   input  logic               CLK,
   input  logic               ASYNCRESET,
   input  logic               flush,
   input  logic [NUM_OUT-1:0] cfg_en,
   input  logic [NUM_OUT-1:0] cfg_sel,
   input  logic               cfg_eager,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [NUM_OUT-1:0] out_valid,
   input  logic [NUM_OUT-1:0] out_ready,
   output logic               busy,
   output logic [CNT_W-1:0]   xfer_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0]  data_mem [DEPTH];
   logic [NUM_OUT-1:0] mask_mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      rd_next;
   logic [AW:0]        occ;
   logic [NUM_OUT-1:0] pending;

   logic [NUM_OUT-1:0] mask_in;
   logic               head_valid;
   logic               all_rdy;
   logic [NUM_OUT-1:0] handshake;
   logic               push;
   logic               write;
   logic               pop;

   assign mask_in    = cfg_en & cfg_sel;
   assign head_valid = (occ != '0);
   assign busy       = head_valid;
   assign in_ready   = ~ASYNCRESET & (occ < OCC_FULL);
   assign out_data   = head_valid ? data_mem[rd_ptr] : '0;
   assign rd_next    = rd_ptr + 1'b1;

   // Only pending channels take part in the lazy all-ready term, so a
   // non-target consumer's ready can never gate delivery.
   assign all_rdy = &(~pending | out_ready);

   always_comb begin
      out_valid = '0;
      if (head_valid) begin
         out_valid = cfg_eager ? pending : (pending & {NUM_OUT{all_rdy}});
      end
   end

   assign handshake = out_valid & out_ready;
   assign push      = in_valid & in_ready;
   // Zero-mask tokens complete the upstream handshake but are never stored.
   assign write     = push & (mask_in != '0) & ~flush;
   // Head retires once every pending bit is clear or clearing this edge.
   assign pop       = head_valid & ((pending & ~handshake) == '0);

   always_ff @(posedge CLK) begin
      if (write) begin
         data_mem[wr_ptr] <= in_data;
         mask_mem[wr_ptr] <= mask_in;
      end
   end

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         pending    <= '0;
         xfer_count <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ     <= '0;
         pending <= '0;
      end else begin
         if (write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_next;
         end
         case ({write, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase

         // pending always mirrors the remaining targets of the current head.
         if (pop) begin
            if (occ > (AW+1)'(1)) begin
               pending <= mask_mem[rd_next];
            end else if (write) begin
               pending <= mask_in;
            end else begin
               pending <= '0;
            end
         end else if (!head_valid && write) begin
            pending <= mask_in;
         end else begin
            pending <= pending & ~handshake;
         end

         if (pop && (xfer_count != {CNT_W{1'b1}})) begin
            xfer_count <= xfer_count + 1'b1;
         end
      end
   end

endmodule
